// File: rtl/bp_wormhole_to_burst_decoupled_if.sv
// Link-side and burst-side handshake bundle for bp_wormhole_to_burst_decoupled.
// The slave modport is the converter's view; master is the source/sink view.
interface bp_wormhole_to_burst_decoupled_if #(
  parameter int flit_width_p    = 64,
  parameter int hdr_width_p     = 128,
  parameter int pr_data_width_p = 128,
  parameter int pr_len_width_p  = 4
);
  logic [flit_width_p-1:0]    link_data_i;
  logic                       link_v_i;
  logic                       link_ready_and_o;
  logic [hdr_width_p-1:0]     pr_hdr_o;
  logic                       pr_hdr_v_o;
  logic                       pr_hdr_ready_and_i;
  logic                       pr_has_data_o;
  logic [pr_len_width_p-1:0]  pr_data_beats_o;
  logic [pr_data_width_p-1:0] pr_data_o;
  logic                       pr_data_v_o;
  logic                       pr_data_ready_and_i;
  logic                       pr_last_data_o;

  modport slave (
    input  link_data_i, link_v_i, pr_hdr_ready_and_i, pr_data_ready_and_i,
    output link_ready_and_o, pr_hdr_o, pr_hdr_v_o, pr_has_data_o, pr_data_beats_o,
           pr_data_o, pr_data_v_o, pr_last_data_o
  );

  modport master (
    output link_data_i, link_v_i, pr_hdr_ready_and_i, pr_data_ready_and_i,
    input  link_ready_and_o, pr_hdr_o, pr_hdr_v_o, pr_has_data_o, pr_data_beats_o,
           pr_data_o, pr_data_v_o, pr_last_data_o
  );
endinterface

// File: rtl/bp_wormhole_to_burst_decoupled.sv
// Wormhole flit stream to BedRock Burst header/data streams with independent
// header and data buffers; beat count and last marker come from the length field.
module bp_wormhole_to_burst_decoupled_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [width_p-1:0] i_data,
  input  logic               i_push,
  output logic               o_full,
  output logic [width_p-1:0] o_data,
  output logic               o_v,
  input  logic               i_pop
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(els_p - 1)) begin
      return {ptr_w_lp{1'b0}};
    end else begin
      return p + ptr_w_lp'(1);
    end
  endfunction

  // Storage, pointers and occupancy; a push into the slot being popped is safe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= {ptr_w_lp{1'b0}};
      r_rptr <= {ptr_w_lp{1'b0}};
      r_cnt  <= {cnt_w_lp{1'b0}};
      for (int i = 0; i < els_p; i++) begin
        r_mem[i] <= {width_p{1'b0}};
      end
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (i_push && !i_pop) begin
        r_cnt <= r_cnt + cnt_w_lp'(1);
      end else if (!i_push && i_pop) begin
        r_cnt <= r_cnt - cnt_w_lp'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_full = (r_cnt == cnt_w_lp'(els_p));
  assign o_v    = (r_cnt != {cnt_w_lp{1'b0}});
  assign o_data = r_mem[r_rptr];
endmodule

module bp_wormhole_to_burst_decoupled #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 0,
  parameter int len_width_p     = 6,
  parameter int cid_width_p     = 0,
  parameter int pr_hdr_width_p  = 114,
  parameter int pr_data_width_p = 128,
  parameter int pr_len_width_p  = 4,
  parameter int hdr_width_p     = cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p,
  parameter int hdr_els_p       = 2,
  parameter int data_els_p      = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  bp_wormhole_to_burst_decoupled_if.slave      bus,
  output logic                                 err_o
);
  localparam int hdr_len_lp   = hdr_width_p / flit_width_p;
  localparam int data_len_lp  = pr_data_width_p / flit_width_p;
  localparam int cnt_w_lp     = len_width_p + 1;
  localparam int hcnt_w_lp    = $clog2(hdr_len_lp + 1);
  localparam int sub_w_lp     = (data_len_lp > 1) ? $clog2(data_len_lp) : 1;
  localparam int hfifo_w_lp   = 1 + pr_len_width_p + hdr_width_p;
  localparam int dfifo_w_lp   = 1 + pr_data_width_p;

  typedef enum logic [0:0] {e_hdr, e_data} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic                       r_live;
  logic [hcnt_w_lp-1:0]       r_hdr_cnt;
  logic [sub_w_lp-1:0]        r_sub_cnt;
  logic [cnt_w_lp-1:0]        r_tot;
  logic [cnt_w_lp-1:0]        r_dflits;
  logic [cnt_w_lp-1:0]        r_beats;
  logic [cnt_w_lp-1:0]        r_rem;
  logic [cnt_w_lp-1:0]        r_brem;
  logic [hdr_width_p-1:0]     r_hdr;
  logic [pr_data_width_p-1:0] r_beat;
  logic                       r_err;

  logic [cnt_w_lp-1:0]        w_tot_live, w_d_live, w_b_live;
  logic                       w_short_live, w_partial_live;
  logic [cnt_w_lp-1:0]        w_tot, w_d, w_b;
  logic                       w_first, w_hdr_last, w_sub_last, w_acc;
  logic [hdr_width_p-1:0]     w_hdr_next;
  logic [pr_data_width_p-1:0] w_beat_next;
  logic                       w_hpush, w_hfull, w_hv, w_hpop;
  logic                       w_dpush, w_dfull, w_dv, w_dpop;
  logic                       w_ready;
  logic [hfifo_w_lp-1:0]      w_hfifo_wdata, w_hfifo_rdata;
  logic [dfifo_w_lp-1:0]      w_dfifo_wdata, w_dfifo_rdata;
  logic                       w_has;
  logic [pr_len_width_p-1:0]  w_beats_m1;

  // Packet geometry as seen from the length field of the flit currently on the link.
  assign w_tot_live     = {1'b0, bus.link_data_i[cord_width_p +: len_width_p]} + cnt_w_lp'(1);
  assign w_short_live   = (w_tot_live < cnt_w_lp'(hdr_len_lp));
  assign w_d_live       = w_short_live ? {cnt_w_lp{1'b0}} : (w_tot_live - cnt_w_lp'(hdr_len_lp));
  assign w_b_live       = w_d_live / cnt_w_lp'(data_len_lp);
  assign w_partial_live = ((w_d_live % cnt_w_lp'(data_len_lp)) != {cnt_w_lp{1'b0}});

  assign w_first    = (r_hdr_cnt == {hcnt_w_lp{1'b0}});
  assign w_tot      = w_first ? w_tot_live : r_tot;
  assign w_d        = w_first ? w_d_live : r_dflits;
  assign w_b        = w_first ? w_b_live : r_beats;
  assign w_hdr_last = (r_hdr_cnt == hcnt_w_lp'(hdr_len_lp - 1)) ||
                      ((cnt_w_lp'(r_hdr_cnt) + cnt_w_lp'(1)) == w_tot);
  assign w_sub_last = (r_sub_cnt == sub_w_lp'(data_len_lp - 1));

  assign w_hpop  = w_hv & bus.pr_hdr_ready_and_i;
  assign w_dpop  = w_dv & bus.pr_data_ready_and_i;
  assign w_acc   = bus.link_v_i & w_ready;
  assign w_hpush = w_acc & (r_state == e_hdr) & w_hdr_last;
  assign w_dpush = w_acc & (r_state == e_data) & w_sub_last & (r_brem != {cnt_w_lp{1'b0}});

  assign w_has         = (w_b != {cnt_w_lp{1'b0}});
  assign w_beats_m1    = w_has ? pr_len_width_p'(w_b - cnt_w_lp'(1)) : {pr_len_width_p{1'b0}};
  assign w_hfifo_wdata = {w_has, w_beats_m1, w_hdr_next};
  assign w_dfifo_wdata = {(r_brem == cnt_w_lp'(1)), w_beat_next};

  // Header slot / beat slot insertion, link ready, and next-state selection.
  always_comb begin
    w_hdr_next   = w_first ? {hdr_width_p{1'b0}} : r_hdr;
    w_beat_next  = r_beat;
    w_ready      = 1'b0;
    w_state_next = r_state;
    for (int i = 0; i < hdr_len_lp; i++) begin
      if (r_hdr_cnt == hcnt_w_lp'(i)) begin
        w_hdr_next[i*flit_width_p +: flit_width_p] = bus.link_data_i;
      end else begin
        w_hdr_next[i*flit_width_p +: flit_width_p] = w_hdr_next[i*flit_width_p +: flit_width_p];
      end
    end
    for (int i = 0; i < data_len_lp; i++) begin
      if (r_sub_cnt == sub_w_lp'(i)) begin
        w_beat_next[i*flit_width_p +: flit_width_p] = bus.link_data_i;
      end else begin
        w_beat_next[i*flit_width_p +: flit_width_p] = r_beat[i*flit_width_p +: flit_width_p];
      end
    end
    case (r_state)
      e_hdr: begin
        w_ready = r_live & (~w_hfull | w_hpop);
        if (w_acc && w_hdr_last && (w_d != {cnt_w_lp{1'b0}})) begin
          w_state_next = e_data;
        end else begin
          w_state_next = e_hdr;
        end
      end
      e_data: begin
        w_ready = r_live & (~w_dfull | w_dpop);
        if (w_acc && (r_rem == cnt_w_lp'(1))) begin
          w_state_next = e_hdr;
        end else begin
          w_state_next = e_data;
        end
      end
      default: begin
        w_ready      = 1'b0;
        w_state_next = e_hdr;
      end
    endcase
  end

  // State register plus the flag that holds the link off while in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_hdr;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  // Header/beat assembly, packet counters and the sticky length error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hdr_cnt <= {hcnt_w_lp{1'b0}};
      r_sub_cnt <= {sub_w_lp{1'b0}};
      r_tot     <= {cnt_w_lp{1'b0}};
      r_dflits  <= {cnt_w_lp{1'b0}};
      r_beats   <= {cnt_w_lp{1'b0}};
      r_rem     <= {cnt_w_lp{1'b0}};
      r_brem    <= {cnt_w_lp{1'b0}};
      r_hdr     <= {hdr_width_p{1'b0}};
      r_beat    <= {pr_data_width_p{1'b0}};
      r_err     <= 1'b0;
    end else if (w_acc && (r_state == e_hdr)) begin
      r_hdr <= w_hdr_next;
      if (w_first) begin
        r_tot    <= w_tot_live;
        r_dflits <= w_d_live;
        r_beats  <= w_b_live;
        r_err    <= r_err | w_short_live | w_partial_live;
      end
      if (w_hdr_last) begin
        r_hdr_cnt <= {hcnt_w_lp{1'b0}};
        r_rem     <= w_d;
        r_brem    <= w_b;
        r_sub_cnt <= {sub_w_lp{1'b0}};
      end else begin
        r_hdr_cnt <= r_hdr_cnt + hcnt_w_lp'(1);
      end
    end else if (w_acc && (r_state == e_data)) begin
      r_beat <= w_beat_next;
      r_rem  <= r_rem - cnt_w_lp'(1);
      if (w_sub_last || (r_rem == cnt_w_lp'(1))) begin
        r_sub_cnt <= {sub_w_lp{1'b0}};
      end else begin
        r_sub_cnt <= r_sub_cnt + sub_w_lp'(1);
      end
      if (w_dpush) begin
        r_brem <= r_brem - cnt_w_lp'(1);
      end
    end else begin
      r_hdr_cnt <= r_hdr_cnt;
    end
  end

  bp_wormhole_to_burst_decoupled_fifo #(.width_p(hfifo_w_lp), .els_p(hdr_els_p)) u_hdr_fifo (
    .i_clk(clk_i), .i_rst_n(reset_n_i), .i_data(w_hfifo_wdata), .i_push(w_hpush),
    .o_full(w_hfull), .o_data(w_hfifo_rdata), .o_v(w_hv), .i_pop(w_hpop)
  );

  bp_wormhole_to_burst_decoupled_fifo #(.width_p(dfifo_w_lp), .els_p(data_els_p)) u_data_fifo (
    .i_clk(clk_i), .i_rst_n(reset_n_i), .i_data(w_dfifo_wdata), .i_push(w_dpush),
    .o_full(w_dfull), .o_data(w_dfifo_rdata), .o_v(w_dv), .i_pop(w_dpop)
  );

  assign bus.link_ready_and_o = w_ready;
  assign bus.pr_hdr_v_o       = w_hv;
  assign {bus.pr_has_data_o, bus.pr_data_beats_o, bus.pr_hdr_o} = w_hfifo_rdata;
  assign bus.pr_data_v_o      = w_dv;
  assign {bus.pr_last_data_o, bus.pr_data_o} = w_dfifo_rdata;
  assign err_o                = r_err;
endmodule

// File: doc/bp_wormhole_to_burst_decoupled.md
# bp_wormhole_to_burst_decoupled

Converts a wormhole link flit stream into BedRock Burst header and data streams, with independent header and data buffers. A new packet's header can be presented while earlier packets' data beats are still draining. The protocol data-beat count and the last-beat marker are derived internally from the wormhole length field, so no consumer feedback is needed. The block sits at wormhole network egress, in front of burst-protocol consumers such as memory controllers and I/O endpoints, and supports flit-to-data width ratios of 1 or greater.

## Interface
- flit_width_p, "inv", link flit width in bits.
- cord_width_p, 0, destination {y,x} coordinate width; occupies flit bits [cord_width_p-1:0].
- len_width_p, "inv", wormhole length field width; located at bits [cord_width_p +: len_width_p].
- cid_width_p, 0, concentrator id width.
- pr_hdr_width_p, "inv", protocol header width.
- pr_data_width_p, "inv", burst data beat width; must be an integer multiple of flit_width_p.
- pr_len_width_p, "inv", width of the beat-count output.
- hdr_width_p, cord_width_p+len_width_p+cid_width_p+pr_hdr_width_p, total header width; must be a multiple of flit_width_p.
- hdr_els_p, 2, header buffer depth in packets; must be at least 1.
- data_els_p, 2, data buffer depth in beats; must be at least 1.
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- link_data_i  in  flit_width_p  incoming flit.
- link_v_i  in  1  flit valid.
- link_ready_and_o  out  1  flit accepted when high together with link_v_i.
- pr_hdr_o  out  hdr_width_p  assembled header; first flit in the LSBs.
- pr_hdr_v_o  out  1  header valid.
- pr_hdr_ready_and_i  in  1  header consumed.
- pr_has_data_o  out  1  packet carries at least one data beat; valid with pr_hdr_v_o.
- pr_data_beats_o  out  pr_len_width_p  number of data beats minus 1; valid with pr_hdr_v_o, 0 when pr_has_data_o=0.
- pr_data_o  out  pr_data_width_p  data beat; earliest flit in the LSBs.
- pr_data_v_o  out  1  data beat valid.
- pr_data_ready_and_i  in  1  data beat consumed.
- pr_last_data_o  out  1  final beat of its packet; valid with pr_data_v_o.
- err_o  out  1  sticky malformed-length flag.

## Operation
- Derived constants:
  - hdr_len_lp = hdr_width_p / flit_width_p.
  - data_len_lp = pr_data_width_p / flit_width_p.
- Wormhole len L means the packet is L+1 flits in total.
- Data flits D = L+1-hdr_len_lp. Beats B = D / data_len_lp.
- Input FSM has two states, e_hdr and e_data; it resets to e_hdr.
- e_hdr:
  - Accepts flits into a header shift register and counts them with hdr_cnt.
  - On the first flit, latches L and computes D.
  - On the last header flit, pushes {hdr, has_data=(D>0), beats=B-1} to the header FIFO.
  - Goes to e_data if D>0; otherwise stays in e_hdr.
  - link_ready_and_o is high unless the header FIFO is full.
  - On the last header flit, link_ready_and_o additionally requires that the FIFO is not full.
- e_data:
  - Accepts flits into a beat accumulator, counting with sub_cnt (0..data_len_lp-1) and decrementing the remaining-flit counter.
  - On each complete beat, pushes {data, last=(remaining flits==0 after this flit)} to the data FIFO.
  - Returns to e_hdr after the final data flit.
  - link_ready_and_o equals data FIFO not-full.
- Malformed packets:
  - L+1 < hdr_len_lp: set err_o; treat the packet as having no data. All L+1 flits are still consumed as header slots.
  - D mod data_len_lp != 0: set err_o. Emit floor(D/data_len_lp) beats and discard the trailing partial flits. If floor(D/data_len_lp) is 0, has_data=0. Otherwise the last full beat carries last=1.
  - err_o clears only on reset.
- The header and data FIFOs are independent. Only the data FIFO orders data beats; packet order is preserved end to end.

## Timing
- Reset (reset_n_i=0, asynchronous):
  - All valid outputs are 0.
  - link_ready_and_o is 0 and err_o is 0.
  - FSM returns to e_hdr and all counters go to 0.
  - FIFOs are emptied.
- Reset asserted mid-packet discards the partial packet. The first flit after reset is treated as a header.
- Header latency: pr_hdr_v_o rises one cycle after the final header flit is accepted.
- Data latency: pr_data_v_o rises one cycle after the final flit of a beat is accepted.
- Backpressure:
  - A full header FIFO stalls the link only in e_hdr.
  - A full data FIFO stalls the link only in e_data.
  - A FIFO push and pop in the same cycle while full is permitted (ready stays high).
- Outputs hold stable while valid is high and the consumer is not ready.
- Sustained throughput is one flit per cycle when consumers are always ready.

## Test plan
Common configuration: flit_width_p=64, cord_width_p=8, len_width_p=6, cid_width_p=0, pr_hdr_width_p=114, pr_data_width_p=128, giving hdr_len_lp=2 and data_len_lp=2.

- Basic packet: send L=5 with flits F0..F5 back to back and consumers always ready.
  - Header: pr_hdr_o={F1,F0} with has_data=1 and beats=1.
  - Data: beats {F3,F2} (last=0), then {F5,F4} (last=1).
  - Each output appears one cycle after its final flit is accepted.
- Header-only packet: send L=1. Expect one header with has_data=0 and beats=0. The FSM stays in e_hdr, and the next flit is parsed as a header.
- Decoupling: hold pr_data_ready_and_i=0 and send two L=5 packets.
  - Both headers are presented and accepted.
  - The link stalls after 2 beats (data FIFO full), then drains in order once ready rises.
- Header backpressure: hold pr_hdr_ready_and_i=0 and send three L=1 packets. link_ready_and_o drops after 4 accepted flits (header FIFO full) and resumes on a pop.
- Malformed length: send L=4 (D=3).
  - err_o=1, beats=0, and one beat {F3,F2} with last=1.
  - F4 is discarded.
  - The next packet parses correctly and err_o stays 1.
- Reset: assert reset_n_i after 3 flits of an L=5 packet.
  - All valid outputs drop immediately and err_o=0.
  - A fresh L=5 packet after deassertion produces the basic-packet response.
